// File: rtl/stop_it_fsm_if.sv
// ============================================================================
// Module   : stop_it_fsm_if
// Purpose  : Button, counter and display signals of the stop-it game controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stop_it_fsm_if #(
  parameter int CNT_W   = 5,
  parameter int SCORE_W = 4
);
  logic               start_i;
  logic               stop_i;
  logic [CNT_W-1:0]   random_i;
  logic [CNT_W-1:0]   count_i;
  logic               counter_en_o;
  logic               counter_clr_o;
  logic [CNT_W-1:0]   target_o;
  logic [SCORE_W-1:0] score_o;
  logic               playing_o;
  logic               win_o;
  logic               lose_o;
  logic               flash_o;

  // The game controller is the slave; the board/testbench side is the master.
  modport slave (
    input  start_i, stop_i, random_i, count_i,
    output counter_en_o, counter_clr_o, target_o, score_o,
           playing_o, win_o, lose_o, flash_o
  );

  modport master (
    output start_i, stop_i, random_i, count_i,
    input  counter_en_o, counter_clr_o, target_o, score_o,
           playing_o, win_o, lose_o, flash_o
  );
endinterface

`default_nettype wire

// File: rtl/stop_it_fsm.sv
// ============================================================================
// Module   : stop_it_fsm
// Purpose  : Stop-it game controller: latches a target, times the round via the
//            external down-counter, judges the stop press and keeps the score.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stop_it_fsm #(
  parameter int CNT_W         = 5,
  parameter int SCORE_W       = 4,
  parameter int START_DELAY   = 4,
  parameter int DISPLAY_TICKS = 8
) (
  input  logic         clk_4_i,
  input  logic         rst_i,
  stop_it_fsm_if.slave bus
);

  localparam int c_TMR_MAX = (START_DELAY > DISPLAY_TICKS) ? START_DELAY : DISPLAY_TICKS;
  localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
  localparam logic [c_TMR_W-1:0] c_START_LAST = c_TMR_W'(START_DELAY - 1);
  localparam logic [c_TMR_W-1:0] c_DISP_LAST  = c_TMR_W'(DISPLAY_TICKS - 1);
  localparam logic [SCORE_W-1:0] c_SCORE_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START_WAIT = 3'd1,
    S_PLAYING    = 3'd2,
    S_WON        = 3'd3,
    S_LOST       = 3'd4
  } state_t;

  state_t             r_state,      w_state_nxt;
  logic [CNT_W-1:0]   r_target,     w_target_nxt;
  logic [SCORE_W-1:0] r_score,      w_score_nxt;
  logic [c_TMR_W-1:0] r_timer,      w_timer_nxt;
  logic               r_flash,      w_flash_nxt;
  logic               r_start_prev;
  logic               r_stop_prev;
  logic               w_start_edge;
  logic               w_stop_edge;
  logic               w_hit;
  logic               w_zero;
  logic               w_counter_en;

  assign w_start_edge = bus.start_i & ~r_start_prev;
  assign w_stop_edge  = bus.stop_i  & ~r_stop_prev;
  assign w_hit        = (bus.count_i == r_target);
  assign w_zero       = (bus.count_i == '0);

  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_target     <= '0;
      r_score      <= '0;
      r_timer      <= '0;
      r_flash      <= 1'b0;
      // History starts high so a button held through reset yields no edge.
      r_start_prev <= 1'b1;
      r_stop_prev  <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_target     <= w_target_nxt;
      r_score      <= w_score_nxt;
      r_timer      <= w_timer_nxt;
      r_flash      <= w_flash_nxt;
      r_start_prev <= bus.start_i;
      r_stop_prev  <= bus.stop_i;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_score_nxt  = r_score;
    w_timer_nxt  = r_timer;
    w_flash_nxt  = r_flash;
    w_counter_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt  = S_START_WAIT;
          w_target_nxt = bus.random_i;
          w_timer_nxt  = '0;
        end
      end
      S_START_WAIT: begin
        if (r_timer == c_START_LAST) begin
          w_state_nxt = S_PLAYING;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_PLAYING: begin
        // Stalling the counter on the deciding cycle freezes the final count.
        w_counter_en = ~w_stop_edge & ~w_zero;
        if (w_stop_edge && w_hit) begin
          w_state_nxt = S_WON;
          w_score_nxt = (r_score == c_SCORE_MAX) ? r_score : r_score + 1'b1;
          w_flash_nxt = 1'b1;
          w_timer_nxt = '0;
        end else if (w_stop_edge || w_zero) begin
          w_state_nxt = S_LOST;
          w_score_nxt = '0;
          w_flash_nxt = 1'b0;
          w_timer_nxt = '0;
        end
      end
      S_WON: begin
        if (r_timer == c_DISP_LAST) begin
          w_state_nxt = S_IDLE;
          w_flash_nxt = 1'b0;
          w_timer_nxt = '0;
        end else begin
          w_flash_nxt = ~r_flash;
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_LOST: begin
        w_flash_nxt = 1'b0;
        if (r_timer == c_DISP_LAST) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
        w_flash_nxt = 1'b0;
      end
    endcase
  end

  assign bus.counter_en_o  = w_counter_en;
  assign bus.counter_clr_o = (r_state == S_START_WAIT);
  assign bus.playing_o     = (r_state == S_PLAYING);
  assign bus.win_o         = (r_state == S_WON);
  assign bus.lose_o        = (r_state == S_LOST);
  assign bus.target_o      = r_target;
  assign bus.score_o       = r_score;
  assign bus.flash_o       = r_flash;

endmodule

`default_nettype wire

// File: tb/tb_stop_it_fsm.sv
// ============================================================================
// Module   : tb_stop_it_fsm
// Purpose  : Randomized scoreboard bench for stop_it_fsm with a round-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stop_it_fsm;
  localparam int CNT_W         = 5;
  localparam int SCORE_W       = 4;
  localparam int START_DELAY   = 4;
  localparam int DISPLAY_TICKS = 8;
  localparam int STOP_TGT      = -2;
  localparam int STOP_NONE     = -1;
  localparam int STOP_WRONG    = -3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stop_it_fsm_if #(.CNT_W(CNT_W), .SCORE_W(SCORE_W)) bus ();

  stop_it_fsm #(
    .CNT_W(CNT_W), .SCORE_W(SCORE_W),
    .START_DELAY(START_DELAY), .DISPLAY_TICKS(DISPLAY_TICKS)
  ) dut (
    .clk_4_i(clk),
    .rst_i  (rst),
    .bus    (bus)
  );

  // Environment model of the round down-counter.
  logic [CNT_W-1:0] count;
  always @(posedge clk or posedge rst) begin
    if (rst)                    count <= 5'd31;
    else if (bus.counter_clr_o) count <= 5'd31;
    else if (bus.counter_en_o)  count <= count - 5'd1;
  end
  assign bus.count_i = count;

  typedef struct {
    bit               win;
    logic [SCORE_W-1:0] score;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tgt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_score = 0;
  bit   force_en = 1'b0;
  logic [CNT_W-1:0] force_val = '0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LFSR stand-in: a new random value every cycle unless a target is forced.
  initial begin
    bus.random_i = '0;
    forever begin
      @(negedge clk);
      bus.random_i = force_en ? force_val : CNT_W'($urandom);
    end
  end

  // Monitor: Mealy enable rule every cycle, outcome/score/freeze on result entry,
  // flash pattern and display length while the result is shown.
  initial begin
    bit               prev_act = 1'b0;
    bit               act;
    bit               was_win = 1'b0;
    int               len = 0;
    logic [CNT_W-1:0] frz = '0;
    exp_t             e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_act = 1'b0;
        len      = 0;
        continue;
      end
      act = bus.win_o | bus.lose_o;
      if (bus.playing_o) begin
        if (count == '0)      check("en_at_zero", bus.counter_en_o, 0);
        else if (bus.stop_i)  check("en_on_stop", bus.counter_en_o, 0);
        else                  check("en_playing", bus.counter_en_o, 1);
      end else begin
        check("en_not_playing", bus.counter_en_o, 0);
      end
      if (act && !prev_act) begin
        if (sb.size() == 0) begin
          check("unexpected_outcome", 1, 0);
        end else begin
          e = sb.pop_front();
          check("outcome_win", bus.win_o, e.win);
          check("outcome_lose", bus.lose_o, !e.win);
          check("score", bus.score_o, e.score);
          check("frozen_count", count, e.cnt);
          check("target", bus.target_o, e.tgt);
        end
        frz     = count;
        was_win = bus.win_o;
        len     = 0;
      end
      if (act) begin
        check("flash", bus.flash_o, (was_win && (len % 2 == 0)) ? 1 : 0);
        len++;
      end
      if (!act && prev_act) begin
        check("display_len", len, DISPLAY_TICKS);
        check("flash_after", bus.flash_o, 0);
        check("count_still_frozen", count, frz);
      end
      prev_act = act;
    end
  end

  task automatic no_round_for(input string name, input int cycles);
    int clr_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.counter_clr_o || bus.playing_o) clr_seen++;
    end
    check(name, clr_seen, 0);
  endtask

  // One game round. stop_cnt: explicit count, STOP_TGT, STOP_WRONG or STOP_NONE.
  task automatic do_round(input int force_tgt, input int stop_cnt, input bit hold_start,
                          input bit poke_display, input int abort_at);
    logic [CNT_W-1:0] tgt;
    int   s;
    int   guard;
    exp_t e;
    if (force_tgt >= 0) begin
      force_en  = 1'b1;
      force_val = CNT_W'(force_tgt);
    end
    tick();
    bus.start_i = 1'b1;
    @(posedge clk);
    tgt = bus.random_i;
    #1;
    if (!hold_start) bus.start_i = 1'b0;
    force_en = 1'b0;

    if (stop_cnt == STOP_TGT)        s = int'(tgt);
    else if (stop_cnt == STOP_WRONG) s = (int'(tgt) + 1 + int'($urandom_range(0, 30))) % 32;
    else                             s = stop_cnt;

    if (abort_at < 0) begin
      e.win       = (s >= 0) && (s == int'(tgt));
      model_score = e.win ? ((model_score < 15) ? model_score + 1 : 15) : 0;
      e.score     = SCORE_W'(model_score);
      e.cnt       = (s >= 0) ? CNT_W'(s) : '0;
      e.tgt       = tgt;
      sb.push_back(e);
    end

    guard = 0;
    while (!bus.playing_o && guard < 20) begin
      tick();
      guard++;
    end
    if (!bus.playing_o) begin
      check("reach_playing", 0, 1);
      return;
    end

    guard = 0;
    while (bus.playing_o && guard < 40) begin
      if (abort_at >= 0 && int'(count) == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_playing", bus.playing_o, 0);
        check("abort_en", bus.counter_en_o, 0);
        check("abort_clr", bus.counter_clr_o, 0);
        check("abort_win_lose", {bus.win_o, bus.lose_o}, 0);
        check("abort_score", bus.score_o, 0);
        check("abort_target", bus.target_o, 0);
        check("abort_flash", bus.flash_o, 0);
        model_score = 0;
        tick();
        rst = 1'b0;
        bus.start_i = 1'b0;
        return;
      end
      if (int'(count) == s) begin
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        break;
      end
      tick();
      guard++;
    end

    guard = 0;
    while (!(bus.win_o || bus.lose_o) && guard < 5) begin
      tick();
      guard++;
    end
    if (poke_display) begin
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
    end
    guard = 0;
    while ((bus.win_o || bus.lose_o) && guard < 30) begin
      tick();
      guard++;
    end
    check("round_back_idle", bus.win_o | bus.lose_o | bus.playing_o, 0);
    if (poke_display) no_round_for("start_in_display_ignored", 10);
    if (hold_start) begin
      no_round_for("held_start_once", 10);
      bus.start_i = 1'b0;
    end
  endtask

  initial begin
    bus.start_i = 1'b1;
    bus.stop_i  = 1'b0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_playing", bus.playing_o, 0);
    check("rst_clr", bus.counter_clr_o, 0);
    check("rst_en", bus.counter_en_o, 0);
    check("rst_win_lose", {bus.win_o, bus.lose_o}, 0);
    check("rst_target", bus.target_o, 0);
    check("rst_score", bus.score_o, 0);
    check("rst_flash", bus.flash_o, 0);
    rst = 1'b0;
    no_round_for("held_start_through_reset", 10);
    bus.start_i = 1'b0;
    tick();

    do_round(5,  STOP_TGT,  1'b0, 1'b0, -1);
    do_round(10, 12,        1'b0, 1'b0, -1);
    do_round(3,  STOP_NONE, 1'b0, 1'b0, -1);
    do_round(0,  0,         1'b0, 1'b0, -1);
    do_round(31, 31,        1'b0, 1'b0, -1);
    do_round(0,  STOP_NONE, 1'b0, 1'b0, -1);
    for (int i = 0; i < 16; i++) do_round(-1, STOP_TGT, 1'b0, 1'b0, -1);
    do_round(-1, STOP_WRONG, 1'b0, 1'b0, -1);
    do_round(-1, STOP_NONE,  1'b1, 1'b0, -1);
    do_round(-1, STOP_TGT,   1'b0, 1'b1, -1);
    do_round(-1, STOP_WRONG, 1'b0, 1'b1, -1);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       do_round(-1, STOP_TGT,   1'b0, 1'b0, -1);
        1:       do_round(-1, STOP_WRONG, 1'b0, 1'b0, -1);
        default: do_round(-1, STOP_NONE,  1'b0, 1'b0, -1);
      endcase
    end
    do_round(-1, STOP_TGT, 1'b0, 1'b0, -1);
    do_round(7,  STOP_NONE, 1'b0, 1'b0, 20);
    do_round(-1, STOP_TGT, 1'b0, 1'b0, -1);

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
